// File: rtl/mem_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and the pipelined memory.
// The slave modport is the arbiter's view; master is the environment driving it.
interface mem_arbiter_if;
   logic        i_req;
   logic [15:0] i_addr;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [15:0] fill_data;
   logic [2:0]  fill_widx;
   logic        i_fill_valid;
   logic        d_fill_valid;
   logic        i_done;
   logic        d_done;
   logic        busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      output fill_data, fill_widx, i_fill_valid, d_fill_valid, i_done, d_done, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      input  fill_data, fill_widx, i_fill_valid, d_fill_valid, i_done, d_done, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache line fills against D-side fills/writes onto a single
// pipelined memory (fixed 4-cycle read latency), alternating on contention.
module mem_arbiter (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_e;

   state_e      state_q;
   logic [2:0]  icnt_q;
   logic [2:0]  rcnt_q;
   logic [2:0]  blk_q;
   logic        last_d_q;
   logic        own_d_q;
   logic        mem_en_q;
   logic        mem_wr_q;
   logic [15:0] mem_addr_q;
   logic [15:0] mem_wdata_q;

   logic rx;
   logic rx_last;
   logic grant_d;
   logic any_req;

   assign any_req = bus.i_req || bus.d_req;
   assign grant_d = bus.d_req && (!bus.i_req || !last_d_q);

   // Returns are only meaningful while a fill owns the bus; anything else is stale.
   assign rx      = rst_n && bus.mem_rvalid && (state_q == ISSUE || state_q == DRAIN);
   assign rx_last = rx && (rcnt_q == 3'd7);

   assign bus.fill_data    = rx ? bus.mem_rdata : '0;
   assign bus.fill_widx    = rx ? rcnt_q : '0;
   assign bus.i_fill_valid = rx && !own_d_q;
   assign bus.d_fill_valid = rx && own_d_q;
   assign bus.i_done       = rx_last && !own_d_q;
   assign bus.d_done       = (rx_last && own_d_q) || (rst_n && state_q == WRITE);
   assign bus.busy         = rst_n && (state_q != IDLE);

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         icnt_q      <= '0;
         rcnt_q      <= '0;
         blk_q       <= 3'd4;
         last_d_q    <= 1'b0;
         own_d_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (blk_q != 3'd0) begin
                  blk_q <= blk_q - 3'd1;
               end else if (any_req) begin
                  last_d_q <= grant_d;
                  own_d_q  <= grant_d;
                  mem_en_q <= 1'b1;
                  if (grant_d && bus.d_we) begin
                     state_q     <= WRITE;
                     mem_wr_q    <= 1'b1;
                     mem_addr_q  <= bus.d_addr;
                     mem_wdata_q <= bus.d_wdata;
                  end else begin
                     state_q    <= ISSUE;
                     mem_addr_q <= (grant_d ? bus.d_addr : bus.i_addr) & 16'hFFF0;
                     icnt_q     <= '0;
                     rcnt_q     <= '0;
                  end
               end
            end
            ISSUE: begin
               if (icnt_q == 3'd7) begin
                  state_q    <= DRAIN;
                  mem_en_q   <= 1'b0;
                  mem_addr_q <= '0;
               end else begin
                  icnt_q     <= icnt_q + 3'd1;
                  mem_addr_q <= mem_addr_q + 16'd2;
               end
            end
            DRAIN: begin
            end
            WRITE: begin
               state_q     <= IDLE;
               mem_en_q    <= 1'b0;
               mem_wr_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase

         // Receive path overrides the case above so the 8th word always ends the fill.
         if (rx) begin
            rcnt_q <= rcnt_q + 3'd1;
            if (rx_last) begin
               state_q    <= IDLE;
               mem_en_q   <= 1'b0;
               mem_addr_q <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle-latency memory model whose
// read data is address ^ 16'hA5A5.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [3:0]  pv = '0;
   logic [15:0] pd0 = '0, pd1 = '0, pd2 = '0, pd3 = '0;
   logic        spur = 1'b0;
   logic [15:0] spur_data = '0;

   always @(posedge clk) begin
      pv  <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
      pd0 <= bus.mem_addr ^ 16'hA5A5;
      pd1 <= pd0;
      pd2 <= pd1;
      pd3 <= pd2;
   end

   assign bus.mem_rvalid = pv[3] | spur;
   assign bus.mem_rdata  = pv[3] ? pd3 : spur_data;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick;
      tick;
      checks++;
      if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== 34'd0) begin
         errors++;
         $display("FAIL reset_mem: got %h expected 0", {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata});
      end
      checks++;
      if ({bus.busy, bus.i_done, bus.d_done, bus.i_fill_valid, bus.d_fill_valid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_status: got %b expected 00000",
                  {bus.busy, bus.i_done, bus.d_done, bus.i_fill_valid, bus.d_fill_valid});
      end
   endtask

   // Request is raised as reset releases; it must wait out the blackout window.
   task automatic test_i_fill;
      rst_n = 1'b1;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h1234;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({bus.busy, bus.mem_en} !== 2'b00) begin
            errors++;
            $display("FAIL blackout c=%0d: got busy,en=%b expected 00", c, {bus.busy, bus.mem_en});
         end
         tick;
      end
      for (int j = 1; j <= 13; j++) begin
         logic [15:0] ea;
         logic [15:0] ed;
         logic [2:0]  w;
         logic        en;
         logic        fv;
         en = (j <= 8);
         ea = en ? 16'h1230 + 16'(2 * (j - 1)) : 16'h0000;
         fv = (j >= 5 && j <= 12);
         w  = fv ? 3'(j - 5) : 3'd0;
         ed = fv ? ((16'h1230 + {12'd0, w, 1'b0}) ^ 16'hA5A5) : 16'h0000;
         checks++;
         if ({bus.mem_en, bus.mem_wr, bus.mem_addr} !== {en, 1'b0, ea}) begin
            errors++;
            $display("FAIL ifill_cmd j=%0d: got %h expected %h", j, {bus.mem_en, bus.mem_wr, bus.mem_addr}, {en, 1'b0, ea});
         end
         checks++;
         if ({bus.i_fill_valid, bus.d_fill_valid, bus.fill_widx, bus.fill_data} !== {fv, 1'b0, w, ed}) begin
            errors++;
            $display("FAIL ifill_data j=%0d: got %h expected %h", j,
                     {bus.i_fill_valid, bus.d_fill_valid, bus.fill_widx, bus.fill_data}, {fv, 1'b0, w, ed});
         end
         checks++;
         if ({bus.i_done, bus.d_done, bus.busy} !== {(j == 12), 1'b0, (j <= 12)}) begin
            errors++;
            $display("FAIL ifill_done_busy j=%0d: got %b expected %b", j,
                     {bus.i_done, bus.d_done, bus.busy}, {(j == 12), 1'b0, (j <= 12)});
         end
         tick;
         if (j == 12) bus.i_req = 1'b0;
      end
   endtask

   task automatic test_write;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 16'h0042;
      bus.d_wdata = 16'hBEEF;
      tick;
      checks++;
      if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {2'b11, 16'h0042, 16'hBEEF}) begin
         errors++;
         $display("FAIL write_cmd: got %h expected %h", {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                  {2'b11, 16'h0042, 16'hBEEF});
      end
      checks++;
      if ({bus.d_done, bus.i_done, bus.busy} !== 3'b101) begin
         errors++;
         $display("FAIL write_done: got %b expected 101", {bus.d_done, bus.i_done, bus.busy});
      end
      tick;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      checks++;
      if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_done, bus.busy} !== 36'd0) begin
         errors++;
         $display("FAIL write_after: got %h expected 0",
                  {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_done, bus.busy});
      end
   endtask

   task automatic test_spurious_rvalid;
      spur      = 1'b1;
      spur_data = 16'h7777;
      #1;
      checks++;
      if ({bus.i_fill_valid, bus.d_fill_valid, bus.fill_widx} !== 5'b0) begin
         errors++;
         $display("FAIL spurious_idle: got %b expected 00000", {bus.i_fill_valid, bus.d_fill_valid, bus.fill_widx});
      end
      tick;
      spur       = 1'b0;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h5678;
      tick;
      checks++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h5670}) begin
         errors++;
         $display("FAIL spurious_next_cmd: got %h expected %h", {bus.mem_en, bus.mem_addr}, {1'b1, 16'h5670});
      end
      repeat (4) tick;
      checks++;
      if ({bus.i_fill_valid, bus.fill_widx, bus.fill_data} !== {1'b1, 3'd0, 16'h5670 ^ 16'hA5A5}) begin
         errors++;
         $display("FAIL spurious_first_word: got %h expected %h", {bus.i_fill_valid, bus.fill_widx, bus.fill_data},
                  {1'b1, 3'd0, 16'h5670 ^ 16'hA5A5});
      end
      repeat (7) tick;
      checks++;
      if (bus.i_done !== 1'b1) begin
         errors++;
         $display("FAIL spurious_next_done: got %b expected 1", bus.i_done);
      end
      tick;
      bus.i_req = 1'b0;
   endtask

   // Both requesters keep requesting; the last owner going in is I, so D, I, D.
   task automatic test_arbitration;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h2000;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 16'h3008;
      tick;
      for (int g = 0; g < 3; g++) begin
         logic        exp_d;
         logic [15:0] base;
         logic        wrong;
         exp_d = (g != 1);
         base  = exp_d ? 16'h3000 : 16'h2000;
         wrong = 1'b0;
         checks++;
         if ({bus.mem_en, bus.mem_addr} !== {1'b1, base}) begin
            errors++;
            $display("FAIL arb_grant g=%0d: got %h expected %h", g, {bus.mem_en, bus.mem_addr}, {1'b1, base});
         end
         for (int k = 0; k < 11; k++) begin
            tick;
            if (exp_d ? bus.i_fill_valid : bus.d_fill_valid) wrong = 1'b1;
         end
         checks++;
         if ({bus.i_done, bus.d_done} !== (exp_d ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL arb_done g=%0d: got %b expected %b", g, {bus.i_done, bus.d_done}, exp_d ? 2'b01 : 2'b10);
         end
         checks++;
         if (wrong !== 1'b0) begin
            errors++;
            $display("FAIL arb_wrong_owner_valid g=%0d: got %b expected 0", g, wrong);
         end
         tick;
         if (g == 2) begin
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
         end
         tick;
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL arb_idle_after: got %b expected 0", bus.busy);
      end
   endtask

   task automatic test_no_preempt;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h401F;
      tick;
      for (int j = 1; j <= 12; j++) begin
         logic [15:0] ea;
         logic [2:0]  w;
         logic        en;
         logic        fv;
         if (j == 3) begin
            bus.d_req  = 1'b1;
            bus.d_we   = 1'b0;
            bus.d_addr = 16'h5000;
         end
         en = (j <= 8);
         ea = en ? 16'h4010 + 16'(2 * (j - 1)) : 16'h0000;
         fv = (j >= 5);
         w  = fv ? 3'(j - 5) : 3'd0;
         checks++;
         if ({bus.mem_en, bus.mem_addr, bus.i_fill_valid, bus.d_fill_valid, bus.fill_widx} !== {en, ea, fv, 1'b0, w}) begin
            errors++;
            $display("FAIL nopreempt j=%0d: got %h expected %h", j,
                     {bus.mem_en, bus.mem_addr, bus.i_fill_valid, bus.d_fill_valid, bus.fill_widx}, {en, ea, fv, 1'b0, w});
         end
         if (j == 12) begin
            checks++;
            if ({bus.i_done, bus.d_done} !== 2'b10) begin
               errors++;
               $display("FAIL nopreempt_idone: got %b expected 10", {bus.i_done, bus.d_done});
            end
         end
         tick;
      end
      bus.i_req = 1'b0;
      tick;
      checks++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h5000}) begin
         errors++;
         $display("FAIL nopreempt_d_grant: got %h expected %h", {bus.mem_en, bus.mem_addr}, {1'b1, 16'h5000});
      end
      repeat (11) tick;
      checks++;
      if ({bus.i_done, bus.d_done} !== 2'b01) begin
         errors++;
         $display("FAIL nopreempt_ddone: got %b expected 01", {bus.i_done, bus.d_done});
      end
      tick;
      bus.d_req = 1'b0;
   endtask

   task automatic test_reset_midfill;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h6000;
      tick;
      repeat (3) tick;
      checks++;
      if (bus.mem_addr !== 16'h6006) begin
         errors++;
         $display("FAIL midreset_word3: got %h expected 6006", bus.mem_addr);
      end
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({bus.mem_en, bus.busy, bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_quiet c=%0d: got %b expected 000000", c,
                     {bus.mem_en, bus.busy, bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done});
         end
         tick;
      end
      checks++;
      if ({bus.mem_en, bus.mem_addr} !== {1'b1, 16'h6000}) begin
         errors++;
         $display("FAIL midreset_reissue: got %h expected %h", {bus.mem_en, bus.mem_addr}, {1'b1, 16'h6000});
      end
      repeat (4) tick;
      checks++;
      if ({bus.i_fill_valid, bus.fill_widx} !== {1'b1, 3'd0}) begin
         errors++;
         $display("FAIL midreset_first_word: got %b expected 1000", {bus.i_fill_valid, bus.fill_widx});
      end
      repeat (7) tick;
      checks++;
      if (bus.i_done !== 1'b1) begin
         errors++;
         $display("FAIL midreset_done: got %b expected 1", bus.i_done);
      end
      tick;
      bus.i_req = 1'b0;
   endtask

   initial begin
      bus.i_req   = 1'b0;
      bus.i_addr  = '0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      test_reset;
      test_i_fill;
      test_write;
      test_spurious_rvalid;
      test_arbitration;
      test_no_preempt;
      test_reset_midfill;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
